// File: rtl/mem_data_bank.sv
// Single-port word memory with per-byte write enables, pipelined reads (1 or 2 edges),
// out-of-range request flagging and an optional zero-fill sweep after reset.
module mem_data_bank #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DEPTH        = 2048,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic                memRead,
  input  logic                memWrite,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                busy,
  output logic                addr_err
);

  localparam int unsigned BE_W = DATA_W / 8;

  localparam logic [0:0] READY = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ADDR_W-1:0] fill_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready_c;
  logic              addr_ok_c;
  logic              rd_req_c;
  logic              wr_req_c;
  logic              fill_last_c;
  logic [ADDR_W-1:0] idx_c;
  logic [DATA_W-1:0] cur_word_c;
  logic [DATA_W-1:0] wr_word_c;
  logic [DATA_W-1:0] rd_word_c;
  logic              pipe_valid_c;
  logic [DATA_W-1:0] pipe_data_c;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
    else     state <= state_nxt;
  end

  // Next state: leave CLEAR on the edge that zeroes the last word
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (fill_last_c) state_nxt = READY;
      default: state_nxt = state;
    endcase
  end

  assign busy = (state == CLEAR);

  // Request decode; the merged word doubles as the write-first read result
  always_comb begin
    ready_c     = (state == READY);
    fill_last_c = (32'(fill_idx) == DEPTH - 1);
    addr_ok_c   = (32'(addr) < DEPTH);
    idx_c       = addr_ok_c ? addr : '0;
    rd_req_c    = ready_c && memRead;
    wr_req_c    = ready_c && memWrite && addr_ok_c;
    cur_word_c  = mem[idx_c];
    wr_word_c   = cur_word_c;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (byte_en[i]) wr_word_c[8*i +: 8] = data_in[8*i +: 8];
    end
    rd_word_c = '0;
    if (addr_ok_c) rd_word_c = memWrite ? wr_word_c : cur_word_c;
    pipe_valid_c = rd_req_c;
    pipe_data_c  = rd_word_c;
    if (RD_LAT == 2) begin
      pipe_valid_c = s1_valid;
      pipe_data_c  = s1_data;
    end
  end

  // Sweep index restarts at 0 on every reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 fill_idx <= '0;
    else if (state == CLEAR) fill_idx <= fill_last_c ? '0 : fill_idx + ADDR_W'(1);
  end

  // Array has no reset; zeroing is done only by the sweep
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[fill_idx] <= '0;
    else if (wr_req_c)  mem[idx_c]    <= wr_word_c;
  end

  // Read pipeline and flags; data is captured at the sampling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      rd_valid <= 1'b0;
      data_out <= '0;
      addr_err <= 1'b0;
    end else begin
      s1_valid <= rd_req_c;
      if (rd_req_c) s1_data <= rd_word_c;
      rd_valid <= pipe_valid_c;
      if (pipe_valid_c) data_out <= pipe_data_c;
      addr_err <= ready_c && (memRead || memWrite) && !addr_ok_c;
    end
  end

endmodule
